// File: rtl/datapath_core.sv
// datapath_core
//   Register/bus datapath for the single-core control FSM. The FSM's load
//   strobes (write_en, one bit per target), bus source code (read_en),
//   increment strobes (inc_en) and ALU function (alu_op) are decoded here.
//   Holds PC, IR, TR, AR, DR, the general registers RA..RT and R, the AC with
//   its ALU, and the registered zero flag z.
//
// Ports
//   clk, rst        rising-edge clock; synchronous active-high reset
//   write_en[16:0]  load strobes: 0 AR, 1 PC, 2 IR<-iram_rdata, 3 TR, 4 DR,
//                   5..12 RA,RB,RO,RN,RP,RC,RR,RT, 13 R, 14 AC<-bus,
//                   15 AC<-ALU, 16 DRAM write
//   read_en[3:0]    bus source code (zero-extended onto the bus)
//   inc_en[1:0]     [0] PC+1, [1] AC+1 (applied on top of any AC load)
//   alu_op[2:0]     ALU function, used with write_en[15]
//   iram_rdata      IRAM read data (IR source)
//   dram_rdata      DRAM read data (bus source 13)
//   instruction     IR
//   z               zero flag of AC, updated whenever AC is written
//   iram_addr       PC
//   dram_addr       AR
//   dram_wdata      bus[7:0], combinational
//   dram_we         write_en[16], combinational
//   ac_out          AC
module datapath_core #(
    parameter int DATA_W  = 16,
    parameter int IRAM_AW = 8,
    parameter int DRAM_AW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [16:0]        write_en,
    input  logic [3:0]         read_en,
    input  logic [1:0]         inc_en,
    input  logic [2:0]         alu_op,
    input  logic [7:0]         iram_rdata,
    input  logic [7:0]         dram_rdata,
    output logic [7:0]         instruction,
    output logic               z,
    output logic [IRAM_AW-1:0] iram_addr,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [7:0]         dram_wdata,
    output logic               dram_we,
    output logic [DATA_W-1:0]  ac_out
);

    // General registers: index 0..7 = RA,RB,RO,RN,RP,RC,RR,RT (write_en[5+i],
    // read_en 4+i); index 8 = R (write_en[13]), the ALU operand, not a bus source.
    localparam int NGPR = 9;

    logic [IRAM_AW-1:0] pc_q, pc_d;
    logic [7:0]         ir_q, ir_d;
    logic [7:0]         tr_q, tr_d;
    logic [7:0]         dr_q, dr_d;
    logic [DRAM_AW-1:0] ar_q, ar_d;
    logic [DATA_W-1:0]  gpr_q [NGPR];
    logic [DATA_W-1:0]  gpr_d [NGPR];
    logic [DATA_W-1:0]  ac_q, ac_d;
    logic               z_q, z_d;

    logic [DATA_W-1:0]  bus;
    logic [DATA_W-1:0]  alu_res;
    logic [DATA_W-1:0]  ac_sel;
    logic               ac_wr;

    function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0]        op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] r);
        logic [DATA_W-1:0] res;
        case (op)
            3'd1:    res = a + r;
            3'd2:    res = a - r;
            3'd3:    res = a * r;   // low DATA_W bits of the product
            3'd4:    res = a - 1'b1;
            3'd5:    res = '0;
            default: res = a;       // 0, 6, 7 pass AC
        endcase
        return res;
    endfunction

    // Bus source mux; every source is zero-extended to DATA_W.
    always_comb begin
        bus = '0;
        case (read_en)
            4'd1:    bus[7:0]  = ir_q;
            4'd2:    bus[7:0]  = tr_q;
            4'd3:    bus[7:0]  = dr_q;
            4'd4:    bus       = gpr_q[0];
            4'd5:    bus       = gpr_q[1];
            4'd6:    bus       = gpr_q[2];
            4'd7:    bus       = gpr_q[3];
            4'd8:    bus       = gpr_q[4];
            4'd9:    bus       = gpr_q[5];
            4'd10:   bus       = gpr_q[6];
            4'd11:   bus       = gpr_q[7];
            4'd12:   bus       = ac_q;
            4'd13:   bus[7:0]  = dram_rdata;
            4'd14:   bus[15:0] = {tr_q, ir_q};
            4'd15:   bus[7:0]  = ac_q[15:8];
            default: bus       = '0;
        endcase
    end

    assign alu_res = alu_fn(alu_op, ac_q, gpr_q[8]);

    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        tr_d = tr_q;
        dr_d = dr_q;
        ar_d = ar_q;
        for (int i = 0; i < NGPR; i++) begin
            gpr_d[i] = gpr_q[i];
        end

        if (write_en[0]) ar_d = bus[DRAM_AW-1:0];
        // A PC load takes priority over the increment.
        if (write_en[1])      pc_d = bus[IRAM_AW-1:0];
        else if (inc_en[0])   pc_d = pc_q + 1'b1;
        if (write_en[2]) ir_d = iram_rdata;
        if (write_en[3]) tr_d = bus[7:0];
        if (write_en[4]) dr_d = bus[7:0];
        for (int i = 0; i < 8; i++) begin
            if (write_en[5+i]) gpr_d[i] = bus;
        end
        if (write_en[13]) gpr_d[8] = bus;

        // AC: ALU result beats bus, and the +1 is applied to whichever was chosen.
        ac_sel = ac_q;
        if (write_en[15])      ac_sel = alu_res;
        else if (write_en[14]) ac_sel = bus;
        ac_wr = write_en[15] | write_en[14] | inc_en[1];
        ac_d  = inc_en[1] ? ac_sel + 1'b1 : ac_sel;
        z_d   = ac_wr ? (ac_d == '0) : z_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
            ir_q <= '0;
            tr_q <= '0;
            dr_q <= '0;
            ar_q <= '0;
            for (int i = 0; i < NGPR; i++) begin
                gpr_q[i] <= '0;
            end
            ac_q <= '0;
            z_q  <= 1'b1;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            tr_q <= tr_d;
            dr_q <= dr_d;
            ar_q <= ar_d;
            for (int i = 0; i < NGPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            ac_q <= ac_d;
            z_q  <= z_d;
        end
    end

    assign instruction = ir_q;
    assign z           = z_q;
    assign iram_addr   = pc_q;
    assign dram_addr   = ar_q;
    assign dram_wdata  = bus[7:0];
    assign dram_we     = write_en[16];
    assign ac_out      = ac_q;

endmodule

// File: tb/tb_datapath_core.sv
module tb_datapath_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] write_en;
    logic [3:0]  read_en;
    logic [1:0]  inc_en;
    logic [2:0]  alu_op;
    logic [7:0]  iram_rdata;
    logic [7:0]  dram_rdata;
    logic [7:0]  instruction;
    logic        z;
    logic [7:0]  iram_addr;
    logic [15:0] dram_addr;
    logic [7:0]  dram_wdata;
    logic        dram_we;
    logic [15:0] ac_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] ac;
        logic        zf;
    } exp_t;
    exp_t sb[$];

    datapath_core #(.DATA_W(16), .IRAM_AW(8), .DRAM_AW(16)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
        .inc_en(inc_en), .alu_op(alu_op), .iram_rdata(iram_rdata),
        .dram_rdata(dram_rdata), .instruction(instruction), .z(z),
        .iram_addr(iram_addr), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_we(dram_we), .ac_out(ac_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [16:0] b(input int i);
        return 17'd1 << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes, then strobes return to idle.
    task automatic step(input logic [16:0] we, input logic [3:0] re,
                        input logic [1:0] inc, input logic [2:0] op);
        write_en = we;
        read_en  = re;
        inc_en   = inc;
        alu_op   = op;
        @(posedge clk);
        #1;
        write_en = '0;
        read_en  = '0;
        inc_en   = '0;
        alu_op   = '0;
    endtask

    task automatic load_ir(input logic [7:0] v);
        iram_rdata = v;
        step(b(2), 4'd0, 2'b00, 3'd0);
    endtask

    task automatic expect_ac(input string tag, input logic [15:0] ac, input logic zf);
        exp_t e;
        e.tag = tag;
        e.ac  = ac;
        e.zf  = zf;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_ac"}, 32'(ac_out), 32'(e.ac));
            chk({e.tag, "_z"}, 32'(z), 32'(e.zf));
        end
    endtask

    initial begin
        rst = 1'b1;
        write_en = '1; read_en = 4'd12; inc_en = 2'b11; alu_op = 3'd1;
        iram_rdata = 8'hAA; dram_rdata = 8'h00;
        #1;
        chk("we_follows_strobe", 32'(dram_we), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pc", 32'(iram_addr), 32'h0);
        chk("rst_ir", 32'(instruction), 32'h0);
        chk("rst_ar", 32'(dram_addr), 32'h0);
        expect_ac("rst", 16'h0000, 1'b1);
        drain();
        write_en = '0; read_en = '0; inc_en = '0; alu_op = '0;
        #1;
        chk("we_idle", 32'(dram_we), 32'd0);
        rst = 1'b0;

        // Registers untouched by the strobes held during reset.
        expect_ac("rst_ra", 16'h0000, 1'b1);
        step(b(14), 4'd4, 2'b00, 3'd0);
        drain();
        expect_ac("rst_tr", 16'h0000, 1'b1);
        step(b(14), 4'd2, 2'b00, 3'd0);
        drain();

        // {TR,IR} onto the bus.
        load_ir(8'h12);
        step(b(3), 4'd1, 2'b00, 3'd0);
        load_ir(8'h34);
        chk("ir_load", 32'(instruction), 32'h34);
        expect_ac("tr_ir", 16'h1234, 1'b0);
        step(b(14), 4'd14, 2'b00, 3'd0);
        drain();

        // Bus load plus increment.
        load_ir(8'hFF);
        step(b(7), 4'd1, 2'b00, 3'd0);
        expect_ac("ro_inc", 16'h0100, 1'b0);
        step(b(14), 4'd6, 2'b10, 3'd0);
        drain();

        // R = 0x0300, then ALU ops.
        load_ir(8'h03);
        step(b(3), 4'd1, 2'b00, 3'd0);
        load_ir(8'h00);
        step(b(13), 4'd14, 2'b00, 3'd0);
        expect_ac("mul", 16'h0000, 1'b1);
        step(b(15), 4'd0, 2'b00, 3'd3);
        drain();
        expect_ac("dec_wrap", 16'hFFFF, 1'b0);
        step(b(15), 4'd0, 2'b00, 3'd4);
        drain();
        expect_ac("add", 16'h02FF, 1'b0);
        step(b(15), 4'd0, 2'b00, 3'd1);
        drain();
        expect_ac("sub", 16'hFFFF, 1'b0);
        step(b(15), 4'd0, 2'b00, 3'd2);
        drain();
        expect_ac("zero_op", 16'h0000, 1'b1);
        step(b(15), 4'd0, 2'b00, 3'd5);
        drain();
        expect_ac("z_hold", 16'h0000, 1'b1);
        step(b(4), 4'd1, 2'b00, 3'd1);
        drain();
        expect_ac("pass_inc", 16'h0001, 1'b0);
        step(b(15), 4'd0, 2'b10, 3'd0);
        drain();
        expect_ac("alu_over_bus", 16'h0001, 1'b0);
        step(b(15) | b(14), 4'd12, 2'b00, 3'd6);
        drain();
        expect_ac("op7_inc", 16'h0002, 1'b0);
        step(b(15), 4'd0, 2'b10, 3'd7);
        drain();
        expect_ac("dec1", 16'h0001, 1'b0);
        step(b(15), 4'd0, 2'b00, 3'd4);
        drain();
        expect_ac("dec0", 16'h0000, 1'b1);
        step(b(15), 4'd0, 2'b00, 3'd4);
        drain();
        expect_ac("inc_only", 16'h0001, 1'b0);
        step('0, 4'd0, 2'b10, 3'd0);
        drain();

        // PC wrap and load-over-increment.
        load_ir(8'hFF);
        step(b(1), 4'd1, 2'b00, 3'd0);
        chk("pc_load", 32'(iram_addr), 32'hFF);
        step('0, 4'd0, 2'b01, 3'd0);
        chk("pc_wrap", 32'(iram_addr), 32'h00);
        load_ir(8'h20);
        step(b(1), 4'd1, 2'b01, 3'd0);
        chk("pc_load_wins", 32'(iram_addr), 32'h20);
        step('0, 4'd0, 2'b01, 3'd0);
        chk("pc_inc", 32'(iram_addr), 32'h21);

        // Several targets from one bus value.
        load_ir(8'h77);
        step(b(5) | b(6) | b(12), 4'd1, 2'b00, 3'd0);
        expect_ac("multi_ra", 16'h0077, 1'b0);
        step(b(14), 4'd4, 2'b00, 3'd0);
        drain();
        expect_ac("multi_rb", 16'h0077, 1'b0);
        step(b(14), 4'd5, 2'b00, 3'd0);
        drain();
        expect_ac("multi_rt", 16'h0077, 1'b0);
        step(b(14), 4'd11, 2'b00, 3'd0);
        drain();

        // DRAM write path, DR load, AR from AC.
        load_ir(8'hAB);
        step(b(3), 4'd1, 2'b00, 3'd0);
        load_ir(8'hCD);
        expect_ac("abcd", 16'hABCD, 1'b0);
        step(b(14), 4'd14, 2'b00, 3'd0);
        drain();
        write_en = b(16) | b(4);
        read_en  = 4'd15;
        #1;
        chk("dram_we", 32'(dram_we), 32'd1);
        chk("dram_wdata", 32'(dram_wdata), 32'hAB);
        @(posedge clk); #1;
        write_en = '0; read_en = '0;
        #1;
        chk("dram_we_off", 32'(dram_we), 32'd0);
        step(b(0), 4'd12, 2'b00, 3'd0);
        chk("ar_from_ac", 32'(dram_addr), 32'hABCD);
        expect_ac("dr_read", 16'h00AB, 1'b0);
        step(b(14), 4'd3, 2'b00, 3'd0);
        drain();
        dram_rdata = 8'h5A;
        expect_ac("dram_rdata", 16'h005A, 1'b0);
        step(b(14), 4'd13, 2'b00, 3'd0);
        drain();

        // Reset in the middle of an operation discards the loads.
        rst = 1'b1;
        load_ir(8'h99);
        rst = 1'b1;
        step(b(14) | b(1) | b(0) | b(5), 4'd12, 2'b11, 3'd1);
        rst = 1'b0;
        chk("midrst_pc", 32'(iram_addr), 32'h0);
        chk("midrst_ar", 32'(dram_addr), 32'h0);
        chk("midrst_ir", 32'(instruction), 32'h0);
        expect_ac("midrst", 16'h0000, 1'b1);
        drain();
        expect_ac("midrst_ra", 16'h0000, 1'b1);
        step(b(14), 4'd4, 2'b00, 3'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
